// File: rtl/pool_pkg.sv
// Shared definitions for the pooling datapath: the window gatherer and the
// 10-input max tree both take their tap count and counter width from here.
package pool_pkg;

  // Number of samples in one pooling window (and max tree inputs).
  localparam int unsigned N_TAPS = 10;

  // Width of the fill and stride counters; must hold the value N_TAPS.
  localparam int unsigned CNT_W = 4;

  // Gatherer control state: still collecting the first window of a line,
  // or running with a full tap register.
  typedef enum logic [0:0] {
    StFill = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/win10_gather.sv
// Serial-to-parallel window former feeding the 10-input max tree.
//
// One BW-bit sample is accepted per din_valid cycle and shifted into a
// 10-entry tap register (tap 0 oldest, tap 9 newest). Once 10 samples of the
// current line are held, a one-cycle strobe (den_out) is raised every STRIDE
// accepted samples; while den_out is high the taps hold exactly that window.
//
// Ports
//   clk                    single clock, posedge
//   rst                    synchronous active-high reset
//   din_valid              din/sof qualified this cycle
//   sof                    first sample of a new line (only with din_valid)
//   din [BW]               input sample
//   data_out0..9 [BW]      window taps, 0 = oldest, 9 = newest
//   den_out                window strobe, registered with the tap shift
module win10_gather
  import pool_pkg::*;
#(
  parameter int unsigned BW     = 8,
  parameter int unsigned STRIDE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  input  logic          sof,
  input  logic [BW-1:0] din,
  output logic [BW-1:0] data_out0,
  output logic [BW-1:0] data_out1,
  output logic [BW-1:0] data_out2,
  output logic [BW-1:0] data_out3,
  output logic [BW-1:0] data_out4,
  output logic [BW-1:0] data_out5,
  output logic [BW-1:0] data_out6,
  output logic [BW-1:0] data_out7,
  output logic [BW-1:0] data_out8,
  output logic [BW-1:0] data_out9,
  output logic          den_out
);

  // Reject strides that cannot be expressed as "windows every 1..10 samples".
  if (STRIDE < 1 || STRIDE > N_TAPS) begin : gen_bad_stride
    $error("win10_gather: STRIDE must be in 1..%0d", N_TAPS);
  end

  // fill_cnt value before the accept that completes the first window.
  localparam logic [CNT_W-1:0] FillLast   = CNT_W'(N_TAPS - 1);
  localparam logic [CNT_W-1:0] FillFull   = CNT_W'(N_TAPS);
  // stride_cnt value before the accept that completes the next window.
  localparam logic [CNT_W-1:0] StrideLast = CNT_W'(STRIDE - 1);

  logic [BW-1:0]    taps_q [N_TAPS];
  logic [BW-1:0]    taps_d [N_TAPS];
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] stride_q, stride_d;
  state_e           state_q, state_d;
  logic             den_q, den_d;

  always_comb begin
    taps_d   = taps_q;
    fill_d   = fill_q;
    stride_d = stride_q;
    state_d  = state_q;
    den_d    = 1'b0;

    if (din_valid) begin
      for (int i = 0; i < N_TAPS - 1; i++) begin
        taps_d[i] = taps_q[i+1];
      end
      taps_d[N_TAPS-1] = din;

      if (sof) begin
        // New line: older taps must never leak into a window of this line.
        for (int i = 0; i < N_TAPS - 1; i++) begin
          taps_d[i] = '0;
        end
        fill_d   = CNT_W'(1);
        stride_d = '0;
        state_d  = StFill;
      end else begin
        case (state_q)
          StFill: begin
            if (fill_q == FillLast) begin
              fill_d   = FillFull;
              stride_d = '0;
              state_d  = StRun;
              den_d    = 1'b1;
            end else begin
              fill_d = fill_q + CNT_W'(1);
            end
          end
          StRun: begin
            // fill_cnt stays saturated at N_TAPS here.
            if (stride_q == StrideLast) begin
              stride_d = '0;
              den_d    = 1'b1;
            end else begin
              stride_d = stride_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = StFill;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q   <= '{default: '0};
      fill_q   <= '0;
      stride_q <= '0;
      state_q  <= StFill;
      den_q    <= 1'b0;
    end else begin
      taps_q   <= taps_d;
      fill_q   <= fill_d;
      stride_q <= stride_d;
      state_q  <= state_d;
      den_q    <= den_d;
    end
  end

  assign data_out0 = taps_q[0];
  assign data_out1 = taps_q[1];
  assign data_out2 = taps_q[2];
  assign data_out3 = taps_q[3];
  assign data_out4 = taps_q[4];
  assign data_out5 = taps_q[5];
  assign data_out6 = taps_q[6];
  assign data_out7 = taps_q[7];
  assign data_out8 = taps_q[8];
  assign data_out9 = taps_q[9];
  assign den_out   = den_q;

endmodule

// File: tb/tb_win10_gather.sv
// Bench for win10_gather: three instances (STRIDE 1, 10, 3) share one input
// stream; a queue-based model of the current line predicts taps and strobes.
module tb_win10_gather;

  localparam int STRIDES [3] = '{1, 10, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] tp  [3][10];
  logic       den [3];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Model: last 10 samples of the current line and number accepted in it.
  logic [7:0]  hist[$];
  int          line_cnt = 0;
  logic        exp_den [3];
  logic [79:0] ew;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    win10_gather #(
      .BW    (8),
      .STRIDE(STRIDES[g])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .din_valid(din_valid),
      .sof      (sof),
      .din      (din),
      .data_out0(tp[g][0]),
      .data_out1(tp[g][1]),
      .data_out2(tp[g][2]),
      .data_out3(tp[g][3]),
      .data_out4(tp[g][4]),
      .data_out5(tp[g][5]),
      .data_out6(tp[g][6]),
      .data_out7(tp[g][7]),
      .data_out8(tp[g][8]),
      .data_out9(tp[g][9]),
      .den_out  (den[g])
    );
  end

  // Drive one cycle, advance the model across the edge, return 1 after it.
  task automatic step(input bit v, input bit s, input bit r, input logic [7:0] d);
    bit acc;
    int idx;
    @(negedge clk);
    din_valid = v;
    sof       = s;
    rst       = r;
    din       = d;
    @(posedge clk);
    acc = v && !r;
    if (r) begin
      hist.delete();
      line_cnt = 0;
    end else if (v) begin
      if (s) begin
        hist.delete();
        line_cnt = 0;
      end
      hist.push_back(d);
      line_cnt++;
      if (hist.size() > 10) void'(hist.pop_front());
    end
    for (int k = 0; k < 3; k++) begin
      exp_den[k] = acc && (line_cnt >= 10) && (((line_cnt - 10) % STRIDES[k]) == 0);
    end
    ew = '0;
    for (int i = 0; i < 10; i++) begin
      idx = hist.size() - 10 + i;
      if (idx >= 0) ew[(9-i)*8 +: 8] = hist[idx];
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    logic [79:0] ow;
    step(0, 0, 1, 8'hAA);
    step(1, 1, 1, 8'h55);  // not accepted while rst is high
    for (int k = 0; k < 3; k++) begin
      ow = {tp[k][0], tp[k][1], tp[k][2], tp[k][3], tp[k][4],
            tp[k][5], tp[k][6], tp[k][7], tp[k][8], tp[k][9]};
      n_vec++;
      if (den[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_den s%0d: got %b want 0", STRIDES[k], den[k]);
      end
      n_vec++;
      if (ow !== 80'h0) begin
        n_err++;
        $display("FAIL reset_taps s%0d: got %h want 0", STRIDES[k], ow);
      end
    end
  endtask

  task automatic test_fill_slide();
    logic [79:0] ow;
    step(0, 0, 1, 8'h00);
    for (int n = 1; n <= 11; n++) begin
      step(1, 0, 0, 8'(n));
      for (int k = 0; k < 3; k++) begin
        ow = {tp[k][0], tp[k][1], tp[k][2], tp[k][3], tp[k][4],
              tp[k][5], tp[k][6], tp[k][7], tp[k][8], tp[k][9]};
        n_vec++;
        if (den[k] !== exp_den[k]) begin
          n_err++;
          $display("FAIL fill_den s%0d n%0d: got %b want %b", STRIDES[k], n, den[k], exp_den[k]);
        end
        n_vec++;
        if (ow !== ew) begin
          n_err++;
          $display("FAIL fill_taps s%0d n%0d: got %h want %h", STRIDES[k], n, ow, ew);
        end
      end
      if (n >= 10) begin
        n_vec++;
        if (den[0] !== 1'b1 || tp[0][0] !== 8'(n - 9) || tp[0][9] !== 8'(n)) begin
          n_err++;
          $display("FAIL fill_window n%0d: got den=%b t0=%0d t9=%0d want den=1 t0=%0d t9=%0d",
                   n, den[0], tp[0][0], tp[0][9], n - 9, n);
        end
      end
    end
  endtask

  task automatic test_stride10();
    logic [79:0] ow;
    int strobes = 0;
    step(0, 0, 1, 8'h00);
    for (int n = 0; n < 30; n++) begin
      step(1, 0, 0, 8'(n));
      if (den[1] === 1'b1) strobes++;
      for (int k = 0; k < 3; k++) begin
        ow = {tp[k][0], tp[k][1], tp[k][2], tp[k][3], tp[k][4],
              tp[k][5], tp[k][6], tp[k][7], tp[k][8], tp[k][9]};
        n_vec++;
        if (den[k] !== exp_den[k]) begin
          n_err++;
          $display("FAIL s10_den s%0d n%0d: got %b want %b", STRIDES[k], n, den[k], exp_den[k]);
        end
        n_vec++;
        if (ow !== ew) begin
          n_err++;
          $display("FAIL s10_taps s%0d n%0d: got %h want %h", STRIDES[k], n, ow, ew);
        end
      end
    end
    n_vec++;
    if (strobes !== 3) begin
      n_err++;
      $display("FAIL s10_count: got %0d strobes want 3", strobes);
    end
  endtask

  task automatic test_gaps();
    logic [79:0] ow;
    int strobes = 0;
    step(0, 0, 1, 8'h00);
    for (int n = 0; n < 40; n++) begin
      step(~n[0], 0, 0, 8'($urandom));
      if (den[0] === 1'b1) strobes++;
      for (int k = 0; k < 3; k++) begin
        ow = {tp[k][0], tp[k][1], tp[k][2], tp[k][3], tp[k][4],
              tp[k][5], tp[k][6], tp[k][7], tp[k][8], tp[k][9]};
        n_vec++;
        if (den[k] !== exp_den[k]) begin
          n_err++;
          $display("FAIL gap_den s%0d c%0d: got %b want %b", STRIDES[k], n, den[k], exp_den[k]);
        end
        n_vec++;
        if (ow !== ew) begin
          n_err++;
          $display("FAIL gap_taps s%0d c%0d: got %h want %h", STRIDES[k], n, ow, ew);
        end
      end
    end
    n_vec++;
    if (strobes !== 11) begin
      n_err++;
      $display("FAIL gap_count: got %0d strobes want 11", strobes);
    end
  endtask

  task automatic test_sof();
    logic [79:0] ow;
    int strobes = 0;
    step(0, 0, 1, 8'h00);
    for (int n = 0; n < 17; n++) begin
      step(1, (n == 7), 0, 8'(8'hA0 + n));
      if (den[0] === 1'b1) strobes++;
      for (int k = 0; k < 3; k++) begin
        ow = {tp[k][0], tp[k][1], tp[k][2], tp[k][3], tp[k][4],
              tp[k][5], tp[k][6], tp[k][7], tp[k][8], tp[k][9]};
        n_vec++;
        if (den[k] !== exp_den[k]) begin
          n_err++;
          $display("FAIL sof_den s%0d n%0d: got %b want %b", STRIDES[k], n, den[k], exp_den[k]);
        end
        n_vec++;
        if (ow !== ew) begin
          n_err++;
          $display("FAIL sof_taps s%0d n%0d: got %h want %h", STRIDES[k], n, ow, ew);
        end
      end
    end
    // 10 post-sof samples: exactly one window, holding only A7..B0.
    n_vec++;
    if (strobes !== 1 || den[0] !== 1'b1 || tp[0][0] !== 8'hA7) begin
      n_err++;
      $display("FAIL sof_window: got %0d strobes den=%b t0=%h want 1 strobe den=1 t0=a7",
               strobes, den[0], tp[0][0]);
    end
  endtask

  task automatic test_mid_reset();
    logic [79:0] ow;
    for (int n = 0; n < 12; n++) step(1, 0, 0, 8'($urandom));
    step(1, 0, 1, 8'hEE);
    n_vec++;
    if (den[0] !== 1'b0 || tp[0][9] !== 8'h00 || tp[0][0] !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset: got den=%b t0=%h t9=%h want all 0", den[0], tp[0][0], tp[0][9]);
    end
    for (int n = 1; n <= 10; n++) begin
      step(1, 0, 0, 8'($urandom));
      for (int k = 0; k < 3; k++) begin
        ow = {tp[k][0], tp[k][1], tp[k][2], tp[k][3], tp[k][4],
              tp[k][5], tp[k][6], tp[k][7], tp[k][8], tp[k][9]};
        n_vec++;
        if (den[k] !== exp_den[k]) begin
          n_err++;
          $display("FAIL rst_den s%0d n%0d: got %b want %b", STRIDES[k], n, den[k], exp_den[k]);
        end
        n_vec++;
        if (ow !== ew) begin
          n_err++;
          $display("FAIL rst_taps s%0d n%0d: got %h want %h", STRIDES[k], n, ow, ew);
        end
      end
      n_vec++;
      if (den[0] !== (n == 10)) begin
        n_err++;
        $display("FAIL rst_strobe n%0d: got %b want %b", n, den[0], (n == 10));
      end
    end
  endtask

  task automatic test_random();
    logic [79:0] ow;
    bit v, s, r;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 40) == 0);
      r = ($urandom_range(0, 150) == 0);
      step(v, s, r, 8'($urandom));
      for (int k = 0; k < 3; k++) begin
        ow = {tp[k][0], tp[k][1], tp[k][2], tp[k][3], tp[k][4],
              tp[k][5], tp[k][6], tp[k][7], tp[k][8], tp[k][9]};
        n_vec++;
        if (den[k] !== exp_den[k]) begin
          n_err++;
          $display("FAIL rnd_den s%0d c%0d: got %b want %b", STRIDES[k], cyc, den[k], exp_den[k]);
        end
        n_vec++;
        if (ow !== ew) begin
          n_err++;
          $display("FAIL rnd_taps s%0d c%0d: got %h want %h", STRIDES[k], cyc, ow, ew);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_slide();
    test_stride10();
    test_gaps();
    test_sof();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
